// File: rtl/circuito_exp5_game.sv
// Sequence-memory game: walks a 16-entry one-hot ROM and compares each entry with the registered switches.
// Seven-segment debug decoders are present only when CIRCUITO_EXP5_DEBUG_HEX_EN is defined.
module circuito_exp5_game (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t    state_q, state_d;
    logic [3:0] cont_q;
    logic [3:0] chaves_q;
    logic [3:0] rom_word;
    logic       fim_c;
    logic       igual;
    logic       pronto_q, acertou_q, errou_q;

    always_comb begin
        rom_word = 4'h1;
        case (cont_q)
            4'd0:  rom_word = 4'h1;
            4'd1:  rom_word = 4'h2;
            4'd2:  rom_word = 4'h4;
            4'd3:  rom_word = 4'h8;
            4'd4:  rom_word = 4'h4;
            4'd5:  rom_word = 4'h2;
            4'd6:  rom_word = 4'h1;
            4'd7:  rom_word = 4'h1;
            4'd8:  rom_word = 4'h2;
            4'd9:  rom_word = 4'h2;
            4'd10: rom_word = 4'h4;
            4'd11: rom_word = 4'h4;
            4'd12: rom_word = 4'h8;
            4'd13: rom_word = 4'h8;
            4'd14: rom_word = 4'h1;
            4'd15: rom_word = 4'h4;
            default: rom_word = 4'h1;
        endcase
    end

    assign fim_c = (cont_q == 4'hF);
    assign igual = (chaves_q == rom_word);

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:     if (iniciar) state_d = PREPARACAO;
            PREPARACAO:  state_d = REGISTRA;
            REGISTRA:    state_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)     state_d = FIM_ERROU;
                else if (fim_c) state_d = FIM_ACERTOU;
                else            state_d = PROXIMO;
            end
            PROXIMO:     state_d = REGISTRA;
            FIM_ACERTOU: if (iniciar) state_d = PREPARACAO;
            FIM_ERROU:   if (iniciar) state_d = PREPARACAO;
            default:     state_d = INICIAL;
        endcase
    end

    // Flags are registered from the next state so they stay exact Moore decodes of state_q;
    // datapath is also cleared on entry to preparacao so a restart shows count 0 immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= INICIAL;
            cont_q    <= '0;
            chaves_q  <= '0;
            pronto_q  <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == PREPARACAO || state_q == PREPARACAO) begin
                cont_q   <= '0;
                chaves_q <= '0;
            end else begin
                if (state_q == PROXIMO)  cont_q   <= cont_q + 4'd1;
                if (state_q == REGISTRA) chaves_q <= chaves;
            end
            pronto_q  <= (state_d == FIM_ACERTOU) || (state_d == FIM_ERROU);
            acertou_q <= (state_d == FIM_ACERTOU);
            errou_q   <= (state_d == FIM_ERROU);
        end
    end

    assign pronto     = pronto_q;
    assign acertou    = acertou_q;
    assign errou      = errou_q;
    assign db_igual   = igual;
    assign db_iniciar = iniciar;

`ifdef CIRCUITO_EXP5_DEBUG_HEX_EN
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
            default: hex7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        db_estado = 7'b1111111;
        case (state_q)
            INICIAL, PREPARACAO, REGISTRA, COMPARACAO,
            PROXIMO, FIM_ACERTOU, FIM_ERROU: db_estado = hex7(state_q);
            default: db_estado = 7'b1111111;
        endcase
    end

    assign db_contagem = hex7(cont_q);
    assign db_memoria  = hex7(rom_word);
    assign db_chaves   = hex7(chaves_q);
`else
    assign db_contagem = '1;
    assign db_memoria  = '1;
    assign db_chaves   = '1;
    assign db_estado   = '1;
`endif

endmodule

// File: tb/tb_circuito_exp5_game.sv
// Directed self-checking bench for circuito_exp5_game; expected 7-seg values follow CIRCUITO_EXP5_DEBUG_HEX_EN.
module tb_circuito_exp5_game;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       pronto, acertou, errou, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rom_ref [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    circuito_exp5_game dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .pronto      (pronto),
        .acertou     (acertou),
        .errou       (errou),
        .db_igual    (db_igual),
        .db_iniciar  (db_iniciar),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_chaves   (db_chaves),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] v);
`ifdef CIRCUITO_EXP5_DEBUG_HEX_EN
        logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
`else
        return 7'b1111111;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic p, input logic a, input logic e);
        check({tag, ".pronto"},  {6'd0, pronto},  {6'd0, p});
        check({tag, ".acertou"}, {6'd0, acertou}, {6'd0, a});
        check({tag, ".errou"},   {6'd0, errou},   {6'd0, e});
    endtask

    // From preparacao (just after edge 1): present entries 0..n-1, each held 3 clocks.
    task automatic play_entries(input int n);
        for (int k = 0; k < n; k++) begin
            chaves = rom_ref[k];
            tick(); tick(); tick();
        end
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        chaves  = 4'h0;
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check("reset.estado",   db_estado,   seg(4'h0));
        check("reset.contagem", db_contagem, seg(4'h0));
        check("reset.chaves",   db_chaves,   seg(4'h0));
        check("reset.memoria",  db_memoria,  seg(4'h1));
        #2 reset = 1'b0;
        tick(); tick();
        check_flags("idle", 1'b0, 1'b0, 1'b0);
        check("idle.estado",   db_estado,   seg(4'h0));
        check("idle.contagem", db_contagem, seg(4'h0));
        check("idle.memoria",  db_memoria,  seg(4'h1));

        // Full winning game.
        iniciar = 1'b1;
        #1;
        check("db_iniciar.hi", {6'd0, db_iniciar}, 7'd1);
        tick();
        iniciar = 1'b0;
        #1;
        check("db_iniciar.lo", {6'd0, db_iniciar}, 7'd0);
        check("win.e1.estado", db_estado, seg(4'h1));
        play_entries(15);
        chaves = rom_ref[15];
        tick(); tick();
        check("win.e48.estado", db_estado, seg(4'h5));
        check("win.e48.igual", {6'd0, db_igual}, 7'd1);
        check_flags("win.e48", 1'b0, 1'b0, 1'b0);
        tick();
        check_flags("win.e49", 1'b1, 1'b1, 1'b0);
        check("win.e49.estado",   db_estado,   seg(4'hA));
        check("win.e49.contagem", db_contagem, seg(4'hF));
        check("win.e49.memoria",  db_memoria,  seg(4'h4));
        tick();
        check_flags("win.hold", 1'b1, 1'b1, 1'b0);
        check("win.hold.estado", db_estado, seg(4'hA));

        // Restart from fim_acertou, then miss on entry 0.
        start_game();
        check_flags("restart", 1'b0, 1'b0, 1'b0);
        check("restart.estado",   db_estado,   seg(4'h1));
        check("restart.contagem", db_contagem, seg(4'h0));
        chaves = 4'h2;
        tick(); tick();
        check_flags("miss0.e3", 1'b0, 1'b0, 1'b0);
        tick();
        check_flags("miss0.e4", 1'b1, 1'b0, 1'b1);
        check("miss0.estado",   db_estado,   seg(4'hE));
        check("miss0.igual",    {6'd0, db_igual}, 7'd0);
        check("miss0.contagem", db_contagem, seg(4'h0));
        check("miss0.chaves",   db_chaves,   seg(4'h2));

        // Entries 0-4 correct, wrong value on entry 5.
        start_game();
        play_entries(5);
        chaves = 4'h1;
        tick(); tick();
        check_flags("miss5.e18", 1'b0, 1'b0, 1'b0);
        tick();
        check_flags("miss5.e19", 1'b1, 1'b0, 1'b1);
        check("miss5.contagem", db_contagem, seg(4'h5));
        check("miss5.estado",   db_estado,   seg(4'hE));

        // Reset during comparacao of entry 7.
        start_game();
        play_entries(7);
        chaves = rom_ref[7];
        tick(); tick();
        check("abort.pre.estado",   db_estado,   seg(4'h5));
        check("abort.pre.contagem", db_contagem, seg(4'h7));
        #2 reset = 1'b1;
        #1;
        check_flags("abort", 1'b0, 1'b0, 1'b0);
        check("abort.estado",   db_estado,   seg(4'h0));
        check("abort.contagem", db_contagem, seg(4'h0));
        check("abort.memoria",  db_memoria,  seg(4'h1));
        #1 reset = 1'b0;
        tick();
        check_flags("abort.idle", 1'b0, 1'b0, 1'b0);
        check("abort.idle.estado", db_estado, seg(4'h0));

        // Replay whole game after the abort.
        start_game();
        play_entries(16);
        check_flags("replay.e49", 1'b1, 1'b1, 1'b0);
        check("replay.estado",   db_estado,   seg(4'hA));
        check("replay.contagem", db_contagem, seg(4'hF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circuito_exp5_game.md
# circuito_exp5_game

Sequence-memory game core. It steps through a fixed 16-entry ROM of one-hot 4-bit values. For each entry it registers the player's `chaves` input and compares it with the ROM word, then ends in a "hit" (all 16 matched) or "miss" (first mismatch) state. It is the top-level datapath plus control unit of the experiment, and drives debug seven-segment displays for board bring-up.

## Interface
- No parameters (ROM depth 16, word width 4, both fixed).
- `clock`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `iniciar`  in  1  start/restart request, sampled on rising edge.
- `chaves`  in  4  player input switches.
- `pronto`  out  1  game finished (either final state).
- `acertou`  out  1  finished, all 16 entries matched.
- `errou`  out  1  finished, mismatch found.
- `db_igual`  out  1  comparator output: registered chaves == current ROM word.
- `db_iniciar`  out  1  direct copy of `iniciar`.
- `db_contagem`  out  7  7-seg of address counter.
- `db_memoria`  out  7  7-seg of current ROM word.
- `db_chaves`  out  7  7-seg of switch register.
- `db_estado`  out  7  7-seg of FSM state code.

## Operation
- Datapath:
  - 4-bit address counter with clear and enable; `fimC` = (count == 15).
  - 4-bit switch register loaded from `chaves`.
  - Async-read ROM addressed by the counter.
  - 4-bit equality comparator.
- ROM contents, address 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex).
- FSM states, with `db_estado` hex code:
  - inicial (0): idle; go to preparacao when `iniciar`=1.
  - preparacao (1): clear counter and register; go to registra.
  - registra (4): load register from `chaves`; go to comparacao.
  - comparacao (5): if not equal, go to fim_errou; else if `fimC`, go to fim_acertou; else go to proximo.
  - proximo (6): increment counter; go to registra.
  - fim_acertou (A): `pronto`=1, `acertou`=1.
  - fim_errou (E): `pronto`=1, `errou`=1.
  - Both final states hold until `iniciar`=1, then go to preparacao.
- `iniciar` is ignored in preparacao, registra, comparacao and proximo.
- Seven-segment encoding, all `db_*` 7-bit outputs:
  - Active-low, bit order {g,f,e,d,c,b,a}.
  - Full hex 0-F, e.g. 0=1000000, 1=1111001, A=0001000, E=0000110.
  - Unused state codes display all-off (1111111).
- `pronto`, `acertou` and `errou` are Moore outputs decoded from the state.

## Timing
- Reset forces, asynchronously:
  - state inicial;
  - counter 0 and register 0;
  - `pronto`/`acertou`/`errou` = 0;
  - `db_estado` shows 0, `db_contagem` shows 0, `db_chaves` shows 0;
  - `db_memoria` shows 1 (ROM[0]).
- Reset mid-game aborts immediately to inicial; no result is flagged.
- Three clocks per matched entry (registra, comparacao, proximo).
- `chaves` is sampled only on the edge that leaves registra.
- Count the edge that samples `iniciar`=1 as edge 1:
  - preparacao at edge 1;
  - entry k is registered at edge 2+3k and compared at edge 3+3k;
  - fim_acertou is reached at edge 49.
- A mismatch on entry k reaches fim_errou at edge 4+3k; the counter stays at k.
- Wrap-around: the counter never increments past 15, because comparacao exits to a final state when `fimC`.
- Restart from a final state: `pronto`/`acertou`/`errou` drop on the edge entering preparacao.

## Configuration
- Macro `CIRCUITO_EXP5_DEBUG_HEX_EN`.
- Defined: the four `db_*` 7-bit outputs are driven by the hex decoders as above.
- Undefined:
  - the four 7-bit outputs are tied to 1111111 (blank) and the decoders are not instantiated;
  - `db_igual`, `db_iniciar` and all game behaviour are unchanged.

## Test plan
- Reset pulse, then idle 2 clocks:
  - `pronto`=`acertou`=`errou`=0;
  - `db_estado`=1000000, `db_contagem`=1000000, `db_memoria`=1111001.
- `iniciar` pulse; present 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4, each held 3 clocks and aligned to registra:
  - `acertou`=1 and `pronto`=1 at edge 49;
  - `db_estado`=0001000;
  - `db_contagem` shows F.
- `iniciar` with `chaves`=2 on entry 0:
  - `errou`=1 and `pronto`=1 at edge 4;
  - `db_estado`=0000110;
  - `db_igual`=0;
  - `db_contagem` shows 0.
- Correct entries 0-4, then 1 on entry 5:
  - `errou` at edge 19;
  - counter shows 5.
- From fim_acertou, pulse `iniciar`:
  - next edge gives state 1;
  - `pronto`=0, counter 0.
- Assert `reset` during comparacao of entry 7:
  - state 0, counter 0, no result flag;
  - a later `iniciar` replays the game from entry 0.
